instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly downstream of the program counter. It takes fetch addresses from the PC, issues word reads to instruction memory, and tolerates variable memory latency by tracking up to DEPTH in-flight or buffered fetches. It returns instructions in order, each tagged with its PC, to decode over a valid/ready handshake. A flush input discards everything fetched so far, so the PC can redirect on jumps.

## Interface
- DEPTH, 4, number of fetch entries (outstanding plus buffered). Power of two, 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge where reset==0.
- pc_in  in  32  fetch address from the program counter.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  the address is accepted this cycle; the PC advances only when pc_valid && pc_ready.
- imem_req  out  1  read request.
- imem_addr  out  32  read address, equal to pc_in.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid. Responses arrive in order, at least 1 cycle after their grant.
- imem_rdata  in  32  read data.
- flush  in  1  discards all entries and in-flight requests.
- instr_valid  out  1  the head instruction is available.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- instr_ready  in  1  decode consumes the head this cycle.

## Operation
- Entry ring of DEPTH slots, each holding {pc, data, filled}. Pointers are alloc_ptr, fill_ptr and head_ptr, each log2(DEPTH) bits wide and wrapping modulo DEPTH.
- Counters:
  - count (0..DEPTH): allocated entries.
  - discard (0..DEPTH): stale responses still to drop.
- credit = (count + discard < DEPTH).
- Request and acceptance:
  - imem_req = pc_valid && credit && !flush && reset.
  - imem_addr = pc_in.
  - pc_ready = imem_req && imem_gnt. Issue happens only on this condition.
- Issue: write pc_in into slot alloc_ptr with filled=0, increment alloc_ptr, increment count.
- Response (imem_rvalid):
  - If discard>0: decrement discard and drop the data.
  - Else if an unfilled entry exists: write imem_rdata into slot fill_ptr, set filled=1, increment fill_ptr.
  - Else: ignore the response; there is no request to match it.
- Output:
  - instr_valid = count>0 && slot[head_ptr].filled.
  - instr and instr_pc come from slot head_ptr; both are 0 when instr_valid==0.
- Pop: when instr_valid && instr_ready, clear filled at the head, increment head_ptr, decrement count.
- Flush (registered effect):
  - discard_next = discard + (number of unfilled entries) − (1 if imem_rvalid this cycle and that response would have been kept or dropped).
  - A response arriving in the flush cycle is always dropped.
  - count, filled bits, and all pointers go to 0.
  - A pop in the same cycle has no effect beyond the flush.
  - No issue in the flush cycle.
- Simultaneous issue, response and pop in one cycle are all legal. count changes by (+issue − pop). No other updates conflict.
- Width rules:
  - count and discard are log2(DEPTH)+1 bits wide.
  - Ignore pc_in alignment; the memory word-aligns the address.

## Timing
- Reset values: pc_ready=0, imem_req=0, imem_addr follows pc_in, instr_valid=0, instr=0, instr_pc=0, count=0, discard=0, all pointers 0.
- Outputs are gated during reset cycles.
- No combinational path from imem_rvalid or imem_rdata to any output. Data written in cycle N is visible on instr and instr_valid in cycle N+1.
- Minimum latency from grant at cycle 0: rvalid at cycle 1, instr_valid at cycle 2.
- Throughput is 1 instruction/cycle in steady state when memory returns every cycle and decode is always ready.
- Full (count+discard==DEPTH): imem_req=0. A pop in cycle N allows issue in cycle N+1, not in the same cycle.
- Empty or head unfilled: instr_valid=0, and instr_ready is ignored.
- The first post-flush issue happens in cycle F+1. Post-flush responses are counted against discard before any new entry.
- Reset in the middle of operation returns to reset values on the next edge. Memory shares the reset and drops its own in-flight reads. A stray rvalid with count==0 and discard==0 is ignored.

## Test plan
- Single fetch: pc_in=0x100, gnt in cycle 0, rvalid with rdata=0xDEADBEEF in cycle 1 → instr_valid=1, instr=0xDEADBEEF, instr_pc=0x100 in cycle 2. Pop with instr_ready=1 → instr_valid=0 in cycle 3.
- Back-pressure: DEPTH=4, instr_ready=0, memory always grants and returns → exactly 4 grants, imem_req=0 afterwards. Head PCs stay in order 0x0, 0x4, 0x8, 0xC after releasing instr_ready.
- Variable latency: grants at cycles 0,1,2; rvalid at 3,7,8 → instructions emerge in issue order with correct PC tags, and no instr_valid before cycle 4.
- Flush with 2 outstanding and 1 buffered: flush=1 → instr_valid=0 next cycle. The next 2 rvalids are dropped. A new fetch of 0x200 afterwards yields instr_pc=0x200 with its own data.
- Flush with coincident rvalid: 3 outstanding, rvalid in the flush cycle → discard=2. Only the 3rd subsequent response becomes visible.
- Reset mid-stream: reset=0 for 1 cycle with count=3 → all outputs return to reset values. A stray rvalid afterwards leaves instr_valid=0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : In-order instruction fetch buffer with latency-tolerant issue,
//            PC tagging and flush-aware discard of stale memory responses.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);

  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]    alloc_ptr, fill_ptr, head_ptr;
  // pending tracks allocated-but-unfilled entries so that a full ring of
  // outstanding requests is distinguishable from an empty one.
  logic [CW-1:0]    count, discard, pending;

  logic          credit, issue, resp_drop, resp_keep, pop;
  logic [CW-1:0] discard_flush;

  always_comb begin
    credit        = ({1'b0, count} + {1'b0, discard}) < DEPTH_SUM;
    imem_req      = pc_valid && credit && !flush && reset;
    imem_addr     = pc_in;
    issue         = imem_req && imem_gnt;
    pc_ready      = issue;
    resp_drop     = imem_rvalid && (discard != '0);
    resp_keep     = imem_rvalid && (discard == '0) && (pending != '0);
    instr_valid   = reset && (count != '0) && slot_filled[head_ptr];
    instr         = instr_valid ? slot_data[head_ptr] : '0;
    instr_pc      = instr_valid ? slot_pc[head_ptr]   : '0;
    pop           = instr_valid && instr_ready;
    discard_flush = discard + pending - CW'(resp_drop || resp_keep);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      count       <= '0;
      pending     <= '0;
      discard     <= '0;
      slot_filled <= '0;
    end else if (flush) begin
      // Every unfilled entry still has a response on its way; those become
      // discards, less the one (if any) consumed in this very cycle.
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      count       <= '0;
      pending     <= '0;
      discard     <= discard_flush;
      slot_filled <= '0;
    end else begin
      if (issue) begin
        alloc_ptr              <= alloc_ptr + PTR_ONE;
        slot_filled[alloc_ptr] <= 1'b0;
      end
      if (resp_keep) begin
        fill_ptr              <= fill_ptr + PTR_ONE;
        slot_filled[fill_ptr] <= 1'b1;
      end
      if (pop) begin
        head_ptr              <= head_ptr + PTR_ONE;
        slot_filled[head_ptr] <= 1'b0;
      end
      if (resp_drop) begin
        discard <= discard - CNT_ONE;
      end
      count   <= count + CW'(issue) - CW'(pop);
      pending <= pending + CW'(issue) - CW'(resp_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      if (issue) begin
        slot_pc[alloc_ptr] <= pc_in;
      end
      if (resp_keep) begin
        slot_data[fill_ptr] <= imem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Testbench for instr_fetch: randomized fetch traffic with a variable-latency
// memory, checked by a scoreboard fed from a queue-level fetch model.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam int NCYC  = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int ready; logic [31:0] data; } mresp_t;

  exp_t        exp_q[$];       // fetched instructions awaiting decode, in order
  logic [31:0] inflight_q[$];  // issued PCs still waiting for their data
  int          disc = 0;       // responses owed to flushed requests
  mresp_t      mem_q[$];       // memory-side outstanding reads

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Per-cycle samples taken by the monitor, consumed at the next rising edge.
  logic        s_rst = 1'b0, s_flush = 1'b0, s_issue = 1'b0, s_rvalid = 1'b0;
  logic        s_grant = 1'b0, s_pcacc = 1'b0;
  logic [31:0] s_pc = '0, s_rdata = '0, s_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step();
    int   used;
    exp_t e;
    if (!s_rst) begin
      exp_q.delete();
      inflight_q.delete();
      disc = 0;
    end else if (s_flush) begin
      used = (s_rvalid && (disc > 0 || inflight_q.size() > 0)) ? 1 : 0;
      disc = disc + inflight_q.size() - used;
      inflight_q.delete();
      exp_q.delete();
    end else begin
      if (s_rvalid) begin
        if (disc > 0) disc--;
        else if (inflight_q.size() > 0) begin
          e.pc   = inflight_q.pop_front();
          e.data = s_rdata;
          exp_q.push_back(e);
        end
      end
      if (s_issue) inflight_q.push_back(s_pc);
    end
  endtask

  initial begin : monitor
    logic exp_req;
    logic exp_v;
    forever begin
      @(negedge clk);
      exp_req = pc_valid && (exp_q.size() + inflight_q.size() + disc < DEPTH) && !flush && reset;
      exp_v   = reset && (exp_q.size() > 0);
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      chk("pc_ready", 64'(pc_ready), 64'(exp_req && imem_gnt));
      chk("imem_addr", 64'(imem_addr), 64'(pc_in));
      chk("instr_valid", 64'(instr_valid), 64'(exp_v));
      if (!instr_valid) begin
        chk("idle_outputs", {instr, instr_pc}, 64'h0);
      end else if (instr_ready && exp_v) begin
        chk("instr", 64'(instr), 64'(exp_q[0].data));
        chk("instr_pc", 64'(instr_pc), 64'(exp_q[0].pc));
        void'(exp_q.pop_front());
      end
      s_rst    = reset;
      s_flush  = flush;
      s_issue  = exp_req && imem_gnt;
      s_pc     = pc_in;
      s_rvalid = imem_rvalid;
      s_rdata  = imem_rdata;
      s_grant  = imem_req && imem_gnt;
      s_addr   = imem_addr;
      s_pcacc  = pc_valid && pc_ready;
    end
  end

  initial begin : stim
    logic [15:0] seq;
    mresp_t      m;
    int          phase;
    seq         = 16'h0;
    reset       = 1'b0;
    pc_in       = 32'h0;
    pc_valid    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_step();
      phase = (c / 250) % 4;
      // Memory side: accept last cycle's grant, forget everything on reset.
      if (!s_rst) mem_q.delete();
      else if (s_grant) begin
        m.ready = (c - 1) + ((phase == 2) ? 1 : $urandom_range(1, 5));
        m.data  = {s_addr[15:0], seq} ^ 32'h5A5A_0000;
        seq++;
        mem_q.push_back(m);
      end
      #1;
      cyc = c;
      if (flush) pc_in = {$urandom_range(0, 32'hFFFF), 2'b00};
      else if (s_pcacc) pc_in = pc_in + 32'd4;
      reset       = !(c < 3 || (phase == 3 && $urandom_range(0, 99) < 2));
      flush       = (phase == 3) ? ($urandom_range(0, 99) < 8) :
                    (phase == 0) ? ($urandom_range(0, 99) < 2) : 1'b0;
      pc_valid    = (phase == 1 || phase == 2) ? 1'b1 : ($urandom_range(0, 99) < 80);
      imem_gnt    = (phase == 1 || phase == 2) ? 1'b1 : ($urandom_range(0, 99) < 75);
      instr_ready = (phase == 1) ? 1'b0 : (phase == 2) ? 1'b1 : ($urandom_range(0, 99) < 65);
      if (mem_q.size() > 0 && mem_q[0].ready <= c && (phase == 2 || $urandom_range(0, 99) < 85)) begin
        m           = mem_q.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = m.data;
      end else if (mem_q.size() == 0 && $urandom_range(0, 99) < 3) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
